// File: rtl/ppu_seq_loader.sv
// ppu_seq_loader: streams a writable config table into the PPU over stb/ack,
// then runs the PPU and captures masked pixel output; timeout drops to ERROR.
module ppu_seq_loader #(
    parameter int DATA_W          = 8,
    parameter int N_BYTES         = 10,
    parameter int MODE_W          = 3,
    parameter int TIMEOUT         = 255,
    parameter int RELOAD_ON_FRAME = 0,
    parameter logic [DATA_W-1:0] PIX_MASK = DATA_W'(8'hFC)
) (
    input  logic                       clk_pix,
    input  logic                       sim_rst,
    input  logic                       cfg_we,
    input  logic [$clog2(N_BYTES)-1:0] cfg_addr,
    input  logic [DATA_W-1:0]          cfg_wdata,
    input  logic                       start,
    input  logic [MODE_W-1:0]          mode_in,
    input  logic                       frame_start,
    output logic                       ppu_sync,
    output logic [MODE_W-1:0]          ppu_mode,
    output logic [DATA_W-1:0]          load_data,
    output logic                       load_stb,
    input  logic                       load_ack,
    input  logic [DATA_W-1:0]          run_data,
    input  logic                       run_stb,
    output logic                       run_ack,
    output logic [DATA_W-1:0]          pix_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int IW = $clog2(N_BYTES);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_t;
    typedef logic [DATA_W-1:0] tbl_t [N_BYTES];

    function automatic tbl_t tbl_init();
        tbl_t t;
        for (int i = 0; i < N_BYTES; i++) begin
            case (i)
                0: t[i] = DATA_W'(42);
                1: t[i] = DATA_W'(123);
                2: t[i] = DATA_W'(87);
                3: t[i] = DATA_W'(255);
                5: t[i] = DATA_W'(198);
                6: t[i] = DATA_W'(76);
                7: t[i] = DATA_W'(34);
                8: t[i] = DATA_W'(210);
                9: t[i] = DATA_W'(182);
                default: t[i] = '0;
            endcase
        end
        return t;
    endfunction

    // Power-up contents only; the table is deliberately untouched by reset.
    tbl_t tbl_q = tbl_init();

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   pix_q, pix_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic                done_q, done_d;
    logic                load_q, run_q, err_q;
    logic                xfer, wr, restart, go, last;
    logic [DATA_W-1:0]   first;

    always_comb begin
        xfer    = state_q == LOAD && load_q && load_ack;
        wr      = cfg_we && state_q != LOAD && 32'(cfg_addr) < N_BYTES;
        restart = start && state_q != LOAD;
        go      = restart || (RELOAD_ON_FRAME != 0 && frame_start && state_q == RUN);
        // A write in the same cycle as the load entry must be visible in byte 0.
        first   = (wr && cfg_addr == '0) ? cfg_wdata : tbl_q[0];
        last    = 32'(idx_q) == N_BYTES - 1;
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        pix_d   = (state_q == RUN && run_stb) ? (run_data & PIX_MASK) : pix_q;
        if (go) begin
            state_d = LOAD;
            idx_d   = '0;
            cnt_d   = '0;
            data_d  = first;
            mode_d  = restart ? mode_in : mode_q;
        end else if (state_q == LOAD) begin
            if (xfer && last) begin
                state_d = RUN;
                idx_d   = '0;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else if (xfer) begin
                idx_d  = idx_q + 1'b1;
                data_d = tbl_q[idx_q + 1'b1];
                cnt_d  = '0;
            end else if (32'(cnt_q) == TIMEOUT) begin
                state_d = ERROR;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (wr)
            tbl_q[cfg_addr] <= cfg_wdata;
    end

    always_ff @(posedge clk_pix or posedge sim_rst) begin
        if (sim_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            pix_q   <= '0;
            mode_q  <= MODE_W'(3);
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pix_q   <= pix_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            load_q  <= state_d == LOAD;
            run_q   <= state_d == RUN;
            err_q   <= state_d == ERROR;
        end
    end

    assign ppu_sync  = load_q;
    assign load_stb  = load_q;
    assign busy      = load_q;
    assign ppu_mode  = mode_q;
    assign load_data = data_q;
    assign run_ack   = run_q;
    assign pix_data  = pix_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_ppu_seq_loader.sv
// tb_ppu_seq_loader: directed vectors for load handshake, capture, timeout,
// table rewrite, frame reload and mid-load reset.
module tb_ppu_seq_loader;
    logic       clk_pix = 1'b0;
    logic       sim_rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic       start = 1'b0;
    logic [2:0] mode_in = '0;
    logic       frame_start = 1'b0;
    logic       ppu_sync, load_stb, run_ack, busy, done, err;
    logic [2:0] ppu_mode;
    logic [7:0] load_data, pix_data;
    logic       load_ack = 1'b0;
    logic [7:0] run_data = '0;
    logic       run_stb = 1'b0;

    int total = 0;
    int bad = 0;
    int e [10] = '{42, 123, 87, 255, 0, 198, 76, 34, 210, 182};

    typedef struct {
        logic       stb;
        logic [7:0] data;
        logic [7:0] pix;
    } rv_t;
    rv_t rv [6];

    ppu_seq_loader #(.RELOAD_ON_FRAME(1)) dut (
        .clk_pix(clk_pix), .sim_rst(sim_rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .mode_in(mode_in), .frame_start(frame_start),
        .ppu_sync(ppu_sync), .ppu_mode(ppu_mode), .load_data(load_data), .load_stb(load_stb),
        .load_ack(load_ack), .run_data(run_data), .run_stb(run_stb), .run_ack(run_ack),
        .pix_data(pix_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sync"}, ppu_sync, 0);
        chk({tag, "_mode"}, ppu_mode, 3);
        chk({tag, "_data"}, load_data, 0);
        chk({tag, "_stb"}, load_stb, 0);
        chk({tag, "_run_ack"}, run_ack, 0);
        chk({tag, "_pix"}, pix_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Called right after the edge that entered LOAD; ack after gap idle cycles per byte.
    task automatic load_bytes(input int gap);
        int n = 0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k <= gap; k++) begin
                chk("load_data", load_data, e[b]);
                chk("load_stb", load_stb, 1);
                if (ppu_sync) n++;
                load_ack = (k == gap);
                tick();
                cfg_we = 1'b0;
            end
        end
        load_ack = 1'b0;
        chk("sync_cycles", n, 10 * (gap + 1));
        chk("done", done, 1);
        chk("end_sync", ppu_sync, 0);
        chk("end_run_ack", run_ack, 1);
        chk("end_err", err, 0);
        tick();
        chk("done_pulse", done, 0);
    endtask

    initial begin
        rv[0] = '{1'b1, 8'hB7, 8'hB4};
        rv[1] = '{1'b0, 8'h00, 8'hB4};
        rv[2] = '{1'b1, 8'hFF, 8'hFC};
        rv[3] = '{1'b0, 8'h13, 8'hFC};
        rv[4] = '{1'b1, 8'h03, 8'h00};
        rv[5] = '{1'b1, 8'h5A, 8'h58};

        repeat (2) tick();
        chk_reset("rst");
        sim_rst = 1'b0;
        tick();

        start = 1'b1; mode_in = 3'd4;
        tick();
        start = 1'b0;
        chk("mode4", ppu_mode, 4);
        chk("busy", busy, 1);
        load_bytes(0);

        for (int i = 0; i < 6; i++) begin
            run_stb = rv[i].stb; run_data = rv[i].data;
            tick();
            chk("pix", pix_data, rv[i].pix);
            chk("run_ack", run_ack, 1);
        end
        run_stb = 1'b0;

        start = 1'b1; mode_in = 3'd5;
        tick();
        start = 1'b0;
        load_bytes(3);
        chk("mode5", ppu_mode, 5);

        start = 1'b1; mode_in = 3'd2;
        tick();
        start = 1'b0;
        repeat (255) tick();
        chk("pre_timeout_err", err, 0);
        chk("pre_timeout_busy", busy, 1);
        tick();
        chk("timeout_err", err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_stb", load_stb, 0);
        chk("timeout_sync", ppu_sync, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("err_sticky", err, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_cleared", err, 0);
        load_bytes(0);

        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 8'h11;
        tick();
        cfg_addr = 4'd12; cfg_wdata = 8'hEE;
        tick();
        cfg_we = 1'b0;
        e[3] = 8'h11;
        mode_in = 3'd6; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("reload_busy", busy, 1);
        chk("reload_mode", ppu_mode, 2);
        cfg_we = 1'b1; cfg_addr = 4'd5; cfg_wdata = 8'h99;
        load_bytes(0);

        mode_in = 3'd1; start = 1'b1;
        tick();
        start = 1'b0; load_ack = 1'b1;
        repeat (5) tick();
        chk("mid_byte5", load_data, e[5]);
        sim_rst = 1'b1;
        #1;
        chk_reset("midrst");
        load_ack = 1'b0;
        tick();
        sim_rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_byte0", load_data, 42);
        load_bytes(0);

        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 8'h77; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        e[0] = 8'h77;
        load_bytes(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ppu_seq_loader.md
Name: ppu_seq_loader

Overview:
- Parametrised sequencer that owns the PPU configuration handshake.
- Holds an N_BYTES-deep, DATA_W-wide configuration table, writable through a config port.
- On start (and optionally on every frame start), streams the table into the PPU over a stb/ack handshake with sync asserted, then runs the PPU and captures its output for the VGA driver.
- Adds a timeout/error path, live table rewrite and per-frame reload.

Parameters:
- DATA_W, 8, width of table entries, PPU input data and PPU output data
- N_BYTES, 10, table depth and number of bytes per load (2..256)
- MODE_W, 3, PPU mode width
- TIMEOUT, 255, max cycles to wait for load_ack per byte before error (≥1)
- RELOAD_ON_FRAME, 0, 1 = re-run LOAD at each frame_start while in RUN
- PIX_MASK, 8'hFC, DATA_W-bit mask applied to run_data before capture

Ports:
- clk_pix  in  1  pixel clock
- sim_rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  $clog2(N_BYTES)  table write index
- cfg_wdata  in  DATA_W  table write data
- start  in  1  begin load (pulse)
- mode_in  in  MODE_W  PPU mode, latched on accepted start
- frame_start  in  1  one-cycle pulse at frame origin
- ppu_sync  out  1  high while loading
- ppu_mode  out  MODE_W  latched mode
- load_data  out  DATA_W  byte presented to PPU
- load_stb  out  1  load byte valid
- load_ack  in  1  PPU accepted byte
- run_data  in  DATA_W  PPU output data
- run_stb  in  1  PPU output valid
- run_ack  out  1  sequencer ready for output
- pix_data  out  DATA_W  masked captured PPU output
- busy  out  1  state is LOAD
- done  out  1  one-cycle pulse on LOAD→RUN
- err  out  1  sticky, high in ERROR

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; ppu_sync 0, ppu_mode 3, load_data 0, load_stb 0, run_ack 0, pix_data 0, busy 0, done 0, err 0; idx 0, timeout count 0.
- Table contents are not reset. They initialise to 42, 123, 87, 255, 0, 198, 76, 34, 210, 182 for the first 10 entries and 0 beyond.
- States: IDLE, LOAD, RUN, ERROR.
- IDLE, start=1:
  - next cycle LOAD, with idx=0, ppu_sync=1, load_stb=1, load_data=table[0];
  - ppu_mode<=mode_in.
- LOAD:
  - A transfer occurs on a cycle where load_stb=1 and load_ack=1.
  - On a transfer with idx<N_BYTES-1: idx+1, load_data=table[idx+1] the next cycle, timeout count cleared.
  - On a transfer with idx=N_BYTES-1: next cycle RUN, load_stb=0, ppu_sync=0, done=1 for that one cycle, idx=0.
  - Without a transfer: count+1. When count reaches TIMEOUT: next cycle ERROR, load_stb=0, ppu_sync=0, err=1.
  - start is ignored in LOAD.
- RUN:
  - run_ack=1.
  - Each cycle with run_stb=1: pix_data<=run_data & PIX_MASK (1-cycle latency). Otherwise pix_data holds.
  - start=1 → LOAD (same entry as from IDLE, mode re-latched), run_ack=0.
  - RELOAD_ON_FRAME=1 and frame_start=1 → LOAD, mode not re-latched.
  - start and frame_start together: treated as start.
- ERROR:
  - err held high; all strobes low.
  - start → LOAD with err cleared.
- Table writes:
  - Accepted in IDLE, RUN and ERROR. Writes with cfg_addr≥N_BYTES are dropped.
  - Ignored during LOAD so a load is atomic.
  - A write and a start in the same cycle: the write lands first, so the new value is loaded.
- Reset mid-operation: immediate return to reset values. A partially loaded PPU is not reported; the next start reloads all bytes.
- load_data changes only after a transfer or on entry to LOAD (stable while stb high and unacked).

Test Plan:
- Reset, start with mode_in=4, load_ack tied high → bytes 42,123,…,182 on consecutive cycles; ppu_sync high 10 cycles; done pulse on cycle 11; ppu_mode=4.
- load_ack held low 3 cycles per byte → each byte held stable 4 cycles; total load 40 cycles; no err.
- load_ack stuck low, TIMEOUT=255 → err=1 and state ERROR 256 cycles after start. A subsequent start with ack high completes the load and clears err.
- In RUN, run_stb=1 with run_data=8'hB7 → pix_data=8'hB4 next cycle; run_stb=0 → pix_data holds 8'hB4.
- cfg write addr 3=8'h11 in RUN, then RELOAD_ON_FRAME=1 with frame_start pulse → reload sends 8'h11 as 4th byte. A write issued during LOAD is ignored.
- Assert sim_rst at byte 5 of a load → all outputs at reset values in the same cycle; a new start sends from byte 0 (42).
